tile_rom_sched: RTL and testbench
=================================

TILE_ROM_SCHED -- requirements
Module: tile_rom_sched

Interface
REQ-001 SHALL have parameter AW, default 19: GFX ROM word address width.
REQ-002 SHALL have parameter DW, default 32: GFX ROM word data width.
REQ-003 SHALL have port clk_24M, input, 1: the only clock; all logic rising-edge.
REQ-004 SHALL have port nRES, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port rd_req, input, 3: one-cycle render fetch strobes (bit0 fix, bit1 plane A, bit2 plane B).
REQ-006 SHALL have port rd_addr0/rd_addr1/rd_addr2, input, AW each: fetch address, sampled with the matching rd_req bit.
REQ-007 SHALL have port cpu_req, input, 1: level CPU ROM read request (RMRD path).
REQ-008 SHALL have port cpu_addr, input, AW: CPU read address, sampled at grant.
REQ-009 SHALL have port cpu_ack, output, 1: one-cycle CPU read completion pulse.
REQ-010 SHALL have port cpu_data, output, DW: last CPU read data.
REQ-011 SHALL have port mem_req, output, 1: memory request level.
REQ-012 SHALL have port mem_addr, output, AW: memory address, stable while mem_req high.
REQ-013 SHALL have port mem_ack, input, 1: one-cycle completion; mem_data valid in the same cycle.
REQ-014 SHALL have port mem_data, input, DW: memory read data.
REQ-015 SHALL have port lay_data0/lay_data1/lay_data2, output, DW each: per-layer fetched word.
REQ-016 SHALL have port lay_valid, output, 3: one-cycle per-layer data-ready pulses.
REQ-017 SHALL have port overrun, output, 3: sticky per-layer overrun flags.

Function
REQ-018 SHALL keep a pending bit and address register per layer; rd_req[i] sets pending[i] and loads rd_addr_i.
REQ-019 SHALL set overrun[i] when rd_req[i] arrives while pending[i] is already set; the newer address replaces the older one, and only one fetch is issued.
REQ-020 SHALL treat rd_req[i] arriving on the edge that completes layer i as a new pending request, with no overrun.
REQ-021 SHALL run FSM IDLE -> BUSY -> IDLE; in IDLE with any request pending, it grants, moves to BUSY and raises mem_req at the next edge.
REQ-022 SHALL grant by priority fix > A > B > CPU, except per REQ-024.
REQ-023 SHALL arm the CPU request when cpu_req is high and not yet served; after cpu_ack it re-arms only once cpu_req has been sampled low.
REQ-024 SHALL count consecutive render grants made while the CPU request is armed (2-bit counter); when the count is 3, the CPU wins the next grant and the count clears.
REQ-025 SHALL hold mem_req high and mem_addr stable in BUSY until mem_ack is sampled, then drop mem_req and return to IDLE at that edge.
REQ-026 SHALL, at the mem_ack edge, load lay_data_i or cpu_data from mem_data, clear the granted pending bit, and pulse lay_valid[i] or cpu_ack high for exactly the following cycle.
REQ-027 SHALL ignore mem_ack while in IDLE.
REQ-028 SHALL give a minimum latency of 3 edges from the rd_req edge to the lay_valid assertion (request, grant, ack).
REQ-029 SHALL never drop mem_req without a mem_ack, except on reset or timeout.

Reset
REQ-030 SHALL, on nRES low, immediately force: FSM IDLE, mem_req 0, mem_addr 0, lay_valid 0, cpu_ack 0, pending 0, CPU armed 0, streak counter 0, overrun 0, lay_data*/cpu_data 0.
REQ-031 SHALL abandon a reset that lands during BUSY without completion; the memory side tolerates the aborted request.
REQ-032 SHALL resume arbitration on the first edge after nRES deasserts.

Configuration
REQ-033 SHALL, with SCHED_TIMEOUT_EN defined, count BUSY cycles (6-bit); on reaching 63 without mem_ack, drop mem_req, clear the granted pending bit, set overrun for a render grant, and return to IDLE with no valid/ack pulse.
REQ-034 SHALL, without SCHED_TIMEOUT_EN, wait in BUSY indefinitely and omit the timeout counter entirely.

Verification
REQ-035 SHALL cover: single fetch, where rd_req=001 with addr0=0x12345 and mem_ack 2 cycles after mem_req gives mem_addr=0x12345 and lay_valid=001 with lay_data0=mem_data.
REQ-036 SHALL cover: simultaneous rd_req=111, which issues fix, then A, then B, each with one lay_valid pulse in that order.
REQ-037 SHALL cover: CPU starvation, with cpu_req held and rd_req=111 every 4 cycles, where the CPU is granted after exactly 3 render grants and cpu_ack pulses once.
REQ-038 SHALL cover: overrun, where rd_req[1] twice before service gives overrun=010, one fetch only, at the second address.
REQ-039 SHALL cover: reset mid-BUSY, where nRES pulsed low while mem_req is high gives mem_req=0 at once, no lay_valid, and pending clear.
REQ-040 SHALL cover: timeout with SCHED_TIMEOUT_EN, where no mem_ack gives mem_req dropping after 63 BUSY cycles and overrun set for that layer.

Source files
------------

// File: rtl/tile_rom_sched.sv
// Tile ROM fetch scheduler: three render layers (fix, A, B) and a CPU read port share one GFX ROM.
// Define SCHED_TIMEOUT_EN to add a 63-cycle BUSY watchdog that abandons an unanswered fetch.
module tile_rom_sched #(
    parameter int AW = 19,
    parameter int DW = 32
) (
    input  logic          clk_24M,
    input  logic          nRES,
    input  logic [2:0]    rd_req,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] lay_data0,
    output logic [DW-1:0] lay_data1,
    output logic [DW-1:0] lay_data2,
    output logic [2:0]    lay_valid,
    output logic [2:0]    overrun
);

    // Memory handshake: mem_req rises on a grant edge and stays high with mem_addr frozen
    // until mem_ack is sampled high; mem_data is taken on that same edge and mem_req drops.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] G_FIX = 2'd0;
    localparam logic [1:0] G_A   = 2'd1;
    localparam logic [1:0] G_B   = 2'd2;
    localparam logic [1:0] G_CPU = 2'd3;

    state_t        state, state_nxt;
    logic [1:0]    gnt, gnt_nxt;
    logic          grant_fire, done_fire, abort_fire, to_hit;
    logic [AW-1:0] grant_addr;

    logic [2:0]    pending;
    logic [2:0]    clr;
    logic [AW-1:0] addr_q   [3];
    logic [AW-1:0] rd_addr  [3];
    logic [DW-1:0] lay_q    [3];

    logic          cpu_armed;
    logic          cpu_wait_low;
    logic [1:0]    streak;

    assign rd_addr[0] = rd_addr0;
    assign rd_addr[1] = rd_addr1;
    assign rd_addr[2] = rd_addr2;

    assign lay_data0 = lay_q[0];
    assign lay_data1 = lay_q[1];
    assign lay_data2 = lay_q[2];

`ifdef SCHED_TIMEOUT_EN
    logic [5:0] to_cnt;

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            to_cnt <= 6'd0;
        end else if (grant_fire) begin
            to_cnt <= 6'd0;
        end else if (state == BUSY) begin
            to_cnt <= to_cnt + 6'd1;
        end
    end

    // Fires on the edge that would take the count to 63.
    assign to_hit = (to_cnt == 6'd62);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            state <= IDLE;
            gnt   <= G_FIX;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        grant_fire = 1'b0;
        done_fire  = 1'b0;
        abort_fire = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 3'b000 || cpu_armed) begin
                    grant_fire = 1'b1;
                    state_nxt  = BUSY;
                    // A starved CPU wins once three render grants have gone by.
                    if (cpu_armed && (streak == 2'd3 || pending == 3'b000)) begin
                        gnt_nxt = G_CPU;
                    end else if (pending[0]) begin
                        gnt_nxt = G_FIX;
                    end else if (pending[1]) begin
                        gnt_nxt = G_A;
                    end else begin
                        gnt_nxt = G_B;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    done_fire = 1'b1;
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    abort_fire = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_addr = addr_q[0];
        case (gnt_nxt)
            G_FIX:   grant_addr = addr_q[0];
            G_A:     grant_addr = addr_q[1];
            G_B:     grant_addr = addr_q[2];
            default: grant_addr = cpu_addr;
        endcase
    end

    always_comb begin
        clr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            clr[i] = (done_fire || abort_fire) && (gnt == 2'(i));
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            lay_valid <= 3'b000;
            cpu_ack   <= 1'b0;
            cpu_data  <= '0;
            pending   <= 3'b000;
            overrun   <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                addr_q[i] <= '0;
                lay_q[i]  <= '0;
            end
        end else begin
            lay_valid <= 3'b000;
            cpu_ack   <= 1'b0;

            if (grant_fire) begin
                mem_req  <= 1'b1;
                mem_addr <= grant_addr;
            end else if (done_fire || abort_fire) begin
                mem_req <= 1'b0;
            end

            for (int i = 0; i < 3; i++) begin
                if (rd_req[i]) begin
                    addr_q[i] <= rd_addr[i];
                end
                // A strobe on the completing edge starts a fresh request rather than overrunning.
                pending[i] <= rd_req[i] | (pending[i] & ~clr[i]);
                if ((rd_req[i] && pending[i] && !clr[i]) || (abort_fire && gnt == 2'(i))) begin
                    overrun[i] <= 1'b1;
                end
                if (done_fire && gnt == 2'(i)) begin
                    lay_q[i]     <= mem_data;
                    lay_valid[i] <= 1'b1;
                end
            end

            if (done_fire && gnt == G_CPU) begin
                cpu_data <= mem_data;
                cpu_ack  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            cpu_armed    <= 1'b0;
            cpu_wait_low <= 1'b0;
        end else if (done_fire && gnt == G_CPU) begin
            cpu_armed    <= 1'b0;
            cpu_wait_low <= 1'b1;
        end else if (abort_fire && gnt == G_CPU) begin
            cpu_armed    <= 1'b0;
            cpu_wait_low <= 1'b0;
        end else if (cpu_wait_low) begin
            if (!cpu_req) begin
                cpu_wait_low <= 1'b0;
            end
        end else if (cpu_req) begin
            cpu_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            streak <= 2'd0;
        end else if (!cpu_armed) begin
            streak <= 2'd0;
        end else if (grant_fire) begin
            streak <= (gnt_nxt == G_CPU) ? 2'd0 : streak + 2'd1;
        end
    end

endmodule

// File: tb/tb_tile_rom_sched.sv
// Bench for tile_rom_sched: a per-cycle vector table plus hand-written starvation,
// reset-while-busy and watchdog sequences.
module tb_tile_rom_sched;

    localparam int AW = 19;
    localparam int DW = 32;

    logic          clk_24M = 1'b0;
    logic          nRES = 1'b0;
    logic [2:0]    rd_req = 3'b000;
    logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] lay_data0, lay_data1, lay_data2;
    logic [2:0]    lay_valid;
    logic [2:0]    overrun;

    int n_vec = 0;
    int n_bad = 0;

    always #20 clk_24M = ~clk_24M;

    tile_rom_sched #(.AW(AW), .DW(DW)) dut (
        .clk_24M  (clk_24M),
        .nRES     (nRES),
        .rd_req   (rd_req),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_ack  (cpu_ack),
        .cpu_data (cpu_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .lay_data0(lay_data0),
        .lay_data1(lay_data1),
        .lay_data2(lay_data2),
        .lay_valid(lay_valid),
        .overrun  (overrun)
    );

    typedef struct {
        logic [2:0]    rd;
        logic [AW-1:0] a0, a1, a2;
        logic          cpu;
        logic [AW-1:0] caddr;
        logic          ack;
        logic [DW-1:0] mdata;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic [2:0]    e_valid;
        logic          e_cack;
        logic [2:0]    e_ovr;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] rd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic cpu, input logic [AW-1:0] caddr,
                                input logic ack, input logic [DW-1:0] mdata, input logic e_req,
                                input logic [AW-1:0] e_addr, input logic [2:0] e_valid, input logic e_cack,
                                input logic [2:0] e_ovr, input logic [DW-1:0] e_data);
        vec_t v;
        v.rd = rd; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.cpu = cpu; v.caddr = caddr;
        v.ack = ack; v.mdata = mdata; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_cack = e_cack; v.e_ovr = e_ovr; v.e_data = e_data;
        return v;
    endfunction

    function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
        return {13'h1A5, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_req = 3'b000; cpu_req = 1'b0; mem_ack = 1'b0; mem_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRES = 1'b0;
        @(negedge clk_24M);
        @(negedge clk_24M);
        nRES = 1'b1;
    endtask

    initial begin
        int renders, acks, renders_before, w, bad, hi, vld;
        logic [DW-1:0] got_data;

        // Columns: rd a0 a1 a2 cpu caddr ack mdata | req addr valid cack ovr data
        vecs.push_back(mk(3'b001, 19'h12345, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h12345, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h12345, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 3'b001, 0, 3'b000, 32'hCAFE0001));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b111, 19'h00100, 19'h00200, 19'h00300, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h00100, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h11110001, 0, 0, 3'b001, 0, 3'b000, 32'h11110001));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h00200, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h22220002, 0, 0, 3'b010, 0, 3'b000, 32'h22220002));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h00300, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h33330003, 0, 0, 3'b100, 0, 3'b000, 32'h33330003));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b001, 19'h00400, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h00400, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b001, 19'h00500, 0, 0, 0, 0, 1, 32'h44440004, 0, 0, 3'b001, 0, 3'b000, 32'h44440004));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h00500, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h55550005, 0, 0, 3'b001, 0, 3'b000, 32'h55550005));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b001, 19'h00600, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b010, 0, 19'h00700, 0, 0, 0, 0, 0, 1, 19'h00600, 3'b000, 0, 3'b000, 0));
        vecs.push_back(mk(3'b010, 0, 19'h00701, 0, 0, 0, 0, 0, 1, 19'h00600, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h66660006, 0, 0, 3'b001, 0, 3'b010, 32'h66660006));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 19'h00701, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h77770007, 0, 0, 3'b010, 0, 3'b010, 32'h77770007));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 1, 32'h88880008, 0, 0, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 19'h7ABCD, 0, 0, 0, 0, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 19'h7ABCD, 0, 0, 1, 19'h7ABCD, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 32'h99990009, 0, 0, 3'b000, 1, 3'b010, 32'h99990009));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b010, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b010, 0));

        #5;
        chk("reset state", {mem_req, mem_addr, lay_valid, cpu_ack, overrun, lay_data0, lay_data1, lay_data2},
            128'h0);
        chk("reset cpu_data", cpu_data, 0);
        @(negedge clk_24M);
        @(negedge clk_24M);
        nRES = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rd_req = vecs[i].rd; rd_addr0 = vecs[i].a0; rd_addr1 = vecs[i].a1; rd_addr2 = vecs[i].a2;
            cpu_req = vecs[i].cpu; cpu_addr = vecs[i].caddr;
            mem_ack = vecs[i].ack; mem_data = vecs[i].mdata;
            @(negedge clk_24M);
            got_data = vecs[i].e_cack   ? cpu_data  :
                       vecs[i].e_valid[0] ? lay_data0 :
                       vecs[i].e_valid[1] ? lay_data1 :
                       vecs[i].e_valid[2] ? lay_data2 : '0;
            chk($sformatf("vec%0d", i),
                {mem_req, (vecs[i].e_req ? mem_addr : 19'h0), lay_valid, cpu_ack, overrun, got_data},
                {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_cack, vecs[i].e_ovr, vecs[i].e_data});
        end

        // CPU starvation: render fetches keep arriving while the CPU holds its request.
        do_reset();
        cpu_req = 1'b1; cpu_addr = 19'h55555;
        renders = 0; acks = 0; renders_before = -1;
        for (int c = 0; c < 48; c++) begin
            rd_req   = (c % 4 == 0 && c < 32) ? 3'b111 : 3'b000;
            rd_addr0 = 19'h01000 + 19'(c);
            rd_addr1 = 19'h02000 + 19'(c);
            rd_addr2 = 19'h03000 + 19'(c);
            mem_ack  = mem_req;
            mem_data = mdat(mem_addr);
            @(negedge clk_24M);
            if (cpu_ack) begin
                acks++;
                if (acks == 1) begin
                    renders_before = renders;
                    chk("starve cpu_data", cpu_data, mdat(19'h55555));
                end
            end
            renders += $countones(lay_valid);
        end
        chk("starve renders before cpu", 128'(renders_before), 128'd3);
        chk("starve cpu_ack count", 128'(acks), 128'd1);
        idle_inputs();
        for (int c = 0; c < 24; c++) begin
            mem_ack = mem_req; mem_data = mdat(mem_addr);
            @(negedge clk_24M);
        end
        mem_ack = 1'b0;
        @(negedge clk_24M);
        chk("starve drained", mem_req, 0);

        // Reset landing while a fetch is outstanding.
        rd_req = 3'b010; rd_addr1 = 19'h00123;
        @(negedge clk_24M);
        rd_req = 3'b000;
        w = 0;
        while (!mem_req && w < 8) begin
            @(negedge clk_24M);
            w++;
        end
        chk("rst busy req up", {mem_req, mem_addr}, {1'b1, 19'h00123});
        nRES = 1'b0;
        #1;
        chk("rst async clear", {mem_req, mem_addr, lay_valid, cpu_ack, overrun}, 128'h0);
        mem_ack = 1'b1; mem_data = 32'hDEAD0000;
        @(negedge clk_24M);
        @(negedge clk_24M);
        nRES = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_24M);
            mem_ack = 1'b0;
            if (mem_req || lay_valid != 3'b000) bad++;
        end
        chk("rst no refetch", 128'(bad), 128'd0);

        // Unanswered fetch on layer B.
        rd_req = 3'b100; rd_addr2 = 19'h002AA; mem_ack = 1'b0;
        @(negedge clk_24M);
        rd_req = 3'b000;
`ifdef SCHED_TIMEOUT_EN
        hi = 0; vld = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_24M);
            if (mem_req) hi++;
            if (lay_valid != 3'b000) vld++;
        end
        chk("timeout busy cycles", 128'(hi), 128'd63);
        chk("timeout overrun", overrun, 3'b100);
        chk("timeout no valid", 128'(vld), 128'd0);
`else
        hi = 0; vld = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_24M);
            if (mem_req) hi++;
            if (lay_valid != 3'b000) vld++;
        end
        chk("no timeout held", {128'(hi), mem_addr}, {128'd100, 19'h002AA});
        chk("no timeout no valid", 128'(vld), 128'd0);
        mem_ack = 1'b1; mem_data = 32'hBEEF0002;
        @(negedge clk_24M);
        mem_ack = 1'b0;
        chk("late ack", {mem_req, lay_valid, overrun, lay_data2}, {1'b0, 3'b100, 3'b000, 32'hBEEF0002});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
